core_wb_master_pipelined: RTL

Parametrised Wishbone pipelined-mode master between a core load/store unit and the Wishbone interconnect. It keeps up to MAX_OUTSTANDING transactions in flight and honours wb_stall_i. Each transaction returns exactly one response, carrying read data and an error or timeout flag. Replaces the single-transaction, stall-ignoring core bus interface.

---
 rtl/core_wb_pkg.sv | 23 ++
 rtl/core_wb_timeout_counter.sv | 40 ++++
 rtl/core_wb_master_pipelined.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/core_wb_pkg.sv
// Shared types and helpers for the pipelined Wishbone master.
package core_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        ABORT = 2'd2
    } wb_state_e;

    // Wide all-ones pattern; users slice it to their data width.
    localparam logic [1023:0] RDATA_DEFAULT = '1;

    // Bits needed to hold any value in 0..max_val (minimum 1).
    function automatic int unsigned width_for(input int unsigned max_val);
        for (int unsigned i = 1; i < 32; i++) begin
            if ((max_val >> i) == 0) begin
                return i;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/core_wb_timeout_counter.sv
// Counts idle bus cycles; expired_o flags the cycle that would reach TIMEOUT_CYCLES.
module core_wb_timeout_counter
    import core_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = width_for(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i || (TIMEOUT_CYCLES == 0)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires combinationally so the abort lands on the same edge the count would hit the limit.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/core_wb_master_pipelined.sv
// Wishbone pipelined-mode master: multiple in-flight transactions, stall-aware,
// one in-order response per transaction with error/timeout flush.
module core_wb_master_pipelined
    import core_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 28,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SEL_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_stall_i,
    input  logic                  wb_error_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [SEL_WIDTH-1:0]  req_sel,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  busy
);

    localparam int unsigned OW = width_for(MAX_OUTSTANDING);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [DATA_WIDTH-1:0] RD_DEFAULT = RDATA_DEFAULT[DATA_WIDTH-1:0];

    wb_state_e             state_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [OW-1:0]         out_q;
    logic [OW-1:0]         out_d;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_error_q;
    logic                  rsp_timeout_q;

    logic ready;
    logic accept;
    logic in_bus;
    logic has_out;
    logic bus_fail;
    logic bus_ack;
    logic flush;
    logic last_flush;
    logic stb_d;
    logic tmo_clear;
    logic tmo_expired;

    always_comb begin
        in_bus     = (state_q == BUS);
        has_out    = (out_q != '0);
        ready      = (state_q != ABORT) && (out_q < OUT_MAX) && (!stb_q || !wb_stall_i) &&
                     (!has_out || (req_write == we_q));
        accept     = req_valid && ready;
        bus_fail   = in_bus && has_out && (wb_error_i || tmo_expired);
        bus_ack    = in_bus && has_out && wb_ack_i && !wb_error_i;
        flush      = (state_q == ABORT) && has_out;
        last_flush = !has_out || (out_q == OW'(1));
        stb_d      = accept || (stb_q && wb_stall_i);
        tmo_clear  = accept || (in_bus && wb_ack_i);
        out_d      = out_q + OW'(accept) - OW'(bus_ack || bus_fail || flush);
    end

    core_wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_n_i),
        .enable_i (in_bus),
        .clear_i  (tmo_clear),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            wdat_q        <= '0;
            out_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= RD_DEFAULT;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= RD_DEFAULT;
            // All outstanding transactions share one direction, so we_q names the responder.
            rsp_write_q   <= we_q;
            if (accept) begin
                adr_q  <= req_addr;
                sel_q  <= req_sel;
                wdat_q <= req_wdata;
                we_q   <= req_write;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUS;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                    end
                end
                BUS: begin
                    if (bus_fail) begin
                        state_q       <= ABORT;
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= !wb_error_i;
                    end else begin
                        stb_q <= stb_d;
                        if (bus_ack) begin
                            rsp_valid_q <= 1'b1;
                            if (!we_q) begin
                                rsp_rdata_q <= wb_data_i;
                            end
                        end
                        if ((out_d == '0) && !stb_d) begin
                            state_q <= IDLE;
                            cyc_q   <= 1'b0;
                        end
                    end
                end
                ABORT: begin
                    if (flush) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                    end
                    if (last_flush) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_data_o   = wdat_q;
    assign req_ready   = ready;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE) || req_valid;

endmodule
